ds1302_sched: RTL



---
 rtl/ds1302_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ds1302_sched.sv
// Request scheduler for the DS1302 controller: periodic reads, captured set-time
// writes, and a registered time snapshot. Define DS1302_SCHED_READBACK_EN to read back after each write.
module ds1302_sched #(
    parameter int POLL_CYCLES    = 5_000_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_req,
    input  logic [55:0] set_time,
    output logic        set_busy,
    output logic [55:0] time_out,
    output logic        time_valid,
    output logic        time_upd,
    output logic        sec_chg,
    output logic        err_timeout,
    output logic        write_time_req,
    input  logic        write_time_ack,
    output logic [55:0] wr_time,
    output logic        read_time_req,
    input  logic        read_time_ack,
    input  logic [55:0] rd_time
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] POLL_RELOAD  = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

    logic [1:0]    state_reg;
    logic          set_pend_reg;
    logic [55:0]   set_buf_reg;
    logic          poll_pend_reg;
    logic [PW-1:0] poll_cnt_reg;
    logic [TW-1:0] wait_cnt_reg;
    logic          write_req_reg;
    logic          read_req_reg;
    logic [55:0]   wr_time_reg;
    logic [55:0]   time_reg;
    logic          valid_reg;
    logic          upd_reg;
    logic          chg_reg;
    logic          err_reg;

    logic poll_expire;
    logic waiting;

    assign poll_expire = (poll_cnt_reg == '0);
    // A wait cycle is one where a request is outstanding and its ack has not arrived.
    assign waiting = ((state_reg == S_WR) && !write_time_ack) ||
                     ((state_reg == S_RD) && !read_time_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            set_pend_reg  <= 1'b0;
            set_buf_reg   <= '0;
            poll_pend_reg <= 1'b1;
            poll_cnt_reg  <= POLL_RELOAD;
            wait_cnt_reg  <= '0;
            write_req_reg <= 1'b0;
            read_req_reg  <= 1'b0;
            wr_time_reg   <= '0;
            time_reg      <= '0;
            valid_reg     <= 1'b0;
            upd_reg       <= 1'b0;
            chg_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            upd_reg      <= 1'b0;
            chg_reg      <= 1'b0;
            poll_cnt_reg <= poll_expire ? POLL_RELOAD : poll_cnt_reg - PW'(1);

            case (state_reg)
                S_IDLE: begin
                    if (set_pend_reg) begin
                        state_reg     <= S_WR;
                        write_req_reg <= 1'b1;
                        wr_time_reg   <= set_buf_reg;
                        set_pend_reg  <= 1'b0;
                        wait_cnt_reg  <= '0;
                    end else if (poll_pend_reg) begin
                        state_reg     <= S_RD;
                        read_req_reg  <= 1'b1;
                        poll_pend_reg <= 1'b0;
                        wait_cnt_reg  <= '0;
                    end
                end
                S_WR: begin
                    if (write_time_ack) begin
                        state_reg     <= S_IDLE;
                        write_req_reg <= 1'b0;
`ifdef DS1302_SCHED_READBACK_EN
                        poll_pend_reg <= 1'b1;
`endif
                    end
                end
                S_RD: begin
                    if (read_time_ack) begin
                        state_reg    <= S_IDLE;
                        read_req_reg <= 1'b0;
                        time_reg     <= rd_time;
                        valid_reg    <= 1'b1;
                        upd_reg      <= 1'b1;
                        chg_reg      <= (rd_time[7:0] != time_reg[7:0]);
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    write_req_reg <= 1'b0;
                    read_req_reg  <= 1'b0;
                end
            endcase

            // The controller cannot abort, so a timeout only flags; the request stays up.
            if (waiting) begin
                if (wait_cnt_reg != TIMEOUT_MAX) begin
                    wait_cnt_reg <= wait_cnt_reg + TW'(1);
                end
                if (wait_cnt_reg == TIMEOUT_LAST) begin
                    err_reg <= 1'b1;
                end
            end

            // New captures and poll expiries win over the clears made on issue.
            if (set_req) begin
                set_pend_reg <= 1'b1;
                set_buf_reg  <= set_time;
            end
            if (poll_expire) begin
                poll_pend_reg <= 1'b1;
            end
        end
    end

    assign set_busy       = set_pend_reg || (state_reg == S_WR);
    assign time_out       = time_reg;
    assign time_valid     = valid_reg;
    assign time_upd       = upd_reg;
    assign sec_chg        = chg_reg;
    assign err_timeout    = err_reg;
    assign write_time_req = write_req_reg;
    assign read_time_req  = read_req_reg;
    assign wr_time        = wr_time_reg;
endmodule
